// File: rtl/dualmem_ctrl_pkg.sv
// dualmem_ctrl_pkg: shared types and constants for the dualmem word sequencer
//    state_t        : sequencer states
//    BYTES_PER_WORD : byte accesses per 32-bit word
//    BIDX_W         : width of the byte index within a word
package dualmem_ctrl_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int BIDX_W = $clog2(BYTES_PER_WORD);
   typedef enum logic [1:0] {IDLE, BYTE, WAIT, RESP} state_t;
endpackage

// File: rtl/dualmem_rr_arb2.sv
// dualmem_rr_arb2: two-input round-robin arbiter
//    clk, rst_n : clock, asynchronous active-low reset
//    req        : per-requester request
//    adv        : grant strobe, moves the pointer when a grant is issued
//    gnt        : one-hot grant (combinational)
//    ptr        : priority pointer, requester favoured on contention
module dualmem_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt,
   output logic       ptr
);
   always_comb gnt = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
   // after a grant the other requester gets priority
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= 1'b0;
      else if (adv && |gnt) ptr <= gnt[0];
endmodule

// File: rtl/dualmem_word_ctrl.sv
// dualmem_word_ctrl: serves 32-bit word requests from two masters via four byte accesses on one dualmem port
//    clk_i, rst_ni         : clock, asynchronous active-low reset
//    req_i/we_i/addr_i/wdata_i/be_i : per-requester request fields, sampled with gnt_o
//    gnt_o, rvalid_o, rdata_o       : grant pulse, completion pulse, read word
//    mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i : byte-wide RAM port
module dualmem_word_ctrl
   import dualmem_ctrl_pkg::*;
#(
   parameter int RWIDTH = 13
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [1:0]        req_i,
   input  logic [1:0]        we_i,
   input  logic [RWIDTH-3:0] addr_i [2],
   input  logic [31:0]       wdata_i [2],
   input  logic [3:0]        be_i [2],
   output logic [1:0]        gnt_o,
   output logic [1:0]        rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [RWIDTH-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i
);
   state_t state, nstate;
   logic [BIDX_W-1:0] cnt;
   logic owner, we_q, take, busy, widx, ptr;
   logic [RWIDTH-3:0] addr_q;
   logic [31:0] wdata_q, rdata_q;
   logic [3:0] be_q;
   logic [1:0] agnt;
   assign take = (state == IDLE) || (state == RESP);
   assign busy = state == BYTE;
   assign widx = agnt[1];
   dualmem_rr_arb2 u_arb (
      .clk(clk_i),
      .rst_n(rst_ni),
      .req(req_i),
      .adv(take),
      .gnt(agnt),
      .ptr(ptr)
   );
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else state <= nstate;
   always_comb begin
      nstate = state;
      case (state)
         IDLE, RESP: nstate = |req_i ? BYTE : IDLE;
         BYTE: nstate = (cnt == BIDX_W'(BYTES_PER_WORD - 1)) ? WAIT : BYTE;
         WAIT: nstate = RESP;
         default: nstate = IDLE;
      endcase
   end
   always_comb begin
      gnt_o = (rst_ni && take) ? agnt : 2'b00;
      rvalid_o = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      rdata_o = (state == RESP && !we_q) ? rdata_q : 32'h0;
      mem_en_o = busy;
      mem_we_o = busy & we_q & be_q[cnt];
      mem_addr_o = busy ? {addr_q, cnt} : '0;
      mem_wdata_o = busy ? 8'(wdata_q >> {cnt, 3'b000}) : 8'h00;
   end
   // read bytes arrive one cycle after their access; shifting in from the top
   // leaves byte 0 in the low lane after the fourth capture
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         cnt <= '0;
         owner <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         be_q <= '0;
         rdata_q <= '0;
      end else begin
         if (|gnt_o) begin
            owner <= widx;
            we_q <= we_i[widx];
            addr_q <= addr_i[widx];
            wdata_q <= wdata_i[widx];
            be_q <= be_i[widx];
            cnt <= '0;
         end else if (busy) cnt <= cnt + 1'b1;
         if ((busy && cnt != '0) || state == WAIT) rdata_q <= {mem_rdata_i, rdata_q[31:8]};
      end
endmodule

// File: tb/tb_dualmem_word_ctrl.sv
// tb_dualmem_word_ctrl: scoreboard bench for dualmem_word_ctrl with a behavioural byte RAM
module tb_dualmem_word_ctrl;
   localparam int RW = 13;
   localparam int AW = RW - 2;
   typedef struct {logic owner; logic [31:0] data; int due;} exp_t;
   logic clk = 0, rst_n = 0;
   logic [1:0] req = 0, we = 0, gnt, rvalid;
   logic [AW-1:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0] be [2];
   logic [31:0] rdata;
   logic men, mwe;
   logic [RW-1:0] maddr;
   logic [7:0] mwd, mrd;
   logic [7:0] ram [1<<RW];
   logic [7:0] sh [1<<RW];
   exp_t q [$];
   exp_t e;
   int alog [$];
   int cyc, checks, errors, last_c, lastw [2], gcyc [2];
   logic [1:0] last_g;
   bit alt, log_on;
   always #5 clk = ~clk;
   dualmem_word_ctrl #(.RWIDTH(RW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .mem_en_o(men), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwd),
      .mem_rdata_i(mrd)
   );
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (men) begin
         mrd <= ram[maddr];
         if (mwe) ram[maddr] <= mwd;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask
   always @(negedge clk) begin
      if (rvalid != 0) begin
         if (q.size() == 0) chk("spurious_rvalid", 32'(rvalid), 0);
         else begin
            e = q.pop_front();
            chk("rv_owner", 32'(rvalid), e.owner ? 2 : 1);
            chk("rdata", rdata, e.data);
            chk("latency", cyc, e.due);
         end
      end
      if (gnt != 0 && alt) begin
         if (last_c >= 0) begin
            chk("alt_owner", 32'(gnt), 32'(~last_g & 2'b11));
            chk("gnt_gap", cyc - last_c, 6);
         end
         last_g = gnt;
         last_c = cyc;
      end
      if (men && log_on) alog.push_back(int'(maddr));
   end
   function automatic logic [31:0] shw(input int base);
      return {sh[base+3], sh[base+2], sh[base+1], sh[base]};
   endfunction
   function automatic logic [31:0] ramw(input int base);
      return {ram[base+3], ram[base+2], ram[base+1], ram[base]};
   endfunction
   task automatic txn(input int n, input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
      int k;
      bit got;
      int base;
      logic [31:0] old;
      got = 0;
      @(posedge clk) #1;
      req[n] = 1; we[n] = w; addr[n] = a; wdata[n] = d; be[n] = b;
      for (k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (gnt[n]) got = 1;
      end
      lastw[n] = k - 1;
      if (!got) chk("gnt_timeout", 0, 1);
      else begin
         gcyc[n] = cyc;
         base = int'(a) * 4;
         old = shw(base);
         if (w) for (int i = 0; i < 4; i++) if (b[i]) sh[base+i] = d[8*i +: 8];
         q.push_back('{owner: n[0], data: w ? 32'h0 : old, due: cyc + 6});
      end
      @(posedge clk) #1 req[n] = 0;
   endtask
   task automatic drain;
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);
      repeat (2) @(posedge clk);
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_rvalid"}, 32'(rvalid), 0);
      chk({tag, "_rdata"}, rdata, 0);
      chk({tag, "_en"}, 32'(men), 0);
      chk({tag, "_we"}, 32'(mwe), 0);
      chk({tag, "_addr"}, 32'(maddr), 0);
      chk({tag, "_wdata"}, 32'(mwd), 0);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0] v;
      logic [7:0] oldb [4];
      bit got;
      for (int i = 0; i < (1 << RW); i++) begin
         v = 8'($urandom);
         ram[i] <= v;
         sh[i] = v;
      end
      for (int i = 0; i < 2; i++) begin
         addr[i] = 0; wdata[i] = 0; be[i] = 0;
      end
      last_c = -1;
      req = 2'b11;
      repeat (2) @(posedge clk);
      #1 chk_idle("reset");
      req = 0;
      rst_n = 1;
      txn(0, 1, 'h10, 32'hA1B2C3D4, 4'hF);
      drain;
      chk("wr_byte0", 32'(ram['h40]), 32'hD4);
      chk("wr_byte1", 32'(ram['h41]), 32'hC3);
      chk("wr_byte2", 32'(ram['h42]), 32'hB2);
      chk("wr_byte3", 32'(ram['h43]), 32'hA1);
      txn(0, 0, 'h10, 0, 0);
      drain;
      txn(0, 1, 'h20, 32'hFFFFFFFF, 4'hF);
      txn(0, 1, 'h20, 32'h11223344, 4'b0101);
      txn(0, 0, 'h20, 0, 0);
      drain;
      chk("be_merge", ramw('h80), 32'hFF22FF44);
      txn(1, 1, 'h20, 32'h0, 4'h0);
      txn(1, 0, 'h20, 0, 0);
      drain;
      chk("be_zero", ramw('h80), 32'hFF22FF44);
      alt = 1;
      fork
         for (int i = 0; i < 3; i++) txn(0, 0, AW'(i + 1), 0, 0);
         for (int i = 0; i < 3; i++) txn(1, 0, AW'(i + 5), 0, 0);
      join
      drain;
      alt = 0;
      chk("alt_seen", 32'(last_c >= 0), 1);
      log_on = 1;
      txn(1, 0, {AW{1'b1}}, 0, 0);
      drain;
      log_on = 0;
      chk("maxaddr_n", alog.size(), 4);
      for (int i = 0; i < 4 && i < alog.size(); i++) chk("maxaddr", alog[i], 'h1FFC + i);
      for (int i = 0; i < 4; i++) oldb[i] = ram['hC0 + i];
      got = 0;
      @(posedge clk) #1;
      req[0] = 1; we[0] = 1; addr[0] = 'h30; wdata[0] = 32'h55667788; be[0] = 4'hF;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         if (gnt[0]) got = 1;
      end
      chk("rst_gnt", 32'(got), 1);
      @(posedge clk) #1 req[0] = 0;
      @(posedge clk) #1 rst_n = 0;
      #1 chk_idle("midrst");
      @(posedge clk) #1 rst_n = 1;
      sh['hC0] = 8'h88;
      repeat (8) @(posedge clk);
      chk("rst_byte0", 32'(ram['hC0]), 32'h88);
      chk("rst_byte1", 32'(ram['hC1]), 32'(oldb[1]));
      chk("rst_byte3", 32'(ram['hC3]), 32'(oldb[3]));
      fork
         txn(0, 0, 'h30, 0, 0);
         txn(1, 0, 'h10, 0, 0);
      join
      drain;
      chk("rst_ptr", 32'(gcyc[0] < gcyc[1]), 1);
      txn(0, 0, 'h10, 0, 0);
      drain;
      txn(1, 0, 'h20, 0, 0);
      drain;
      chk("single_lat", lastw[1], 0);
      fork
         txn(0, 0, 'h30, 0, 0);
         txn(1, 0, 'h10, 0, 0);
      join
      drain;
      chk("single_ptr", 32'(gcyc[0] < gcyc[1]), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dualmem_word_ctrl.md
# dualmem_word_ctrl

Sequencer that serves 32-bit word read/write requests from two requesters by issuing four consecutive byte accesses to one port of the byte-wide dual-port boot/shared RAM (`dualmem`). It sits between two bus-side masters (e.g. debug/loader and core-side bridge) and a single `dualmem` port. Round-robin arbitration guarantees each requester fair access; byte enables select which bytes are written.

## Interface
- `RWIDTH`, 13: byte address width of the RAM port; word address width is `RWIDTH-2`.
- `clk_i`  in  1  single clock; RAM port clock is driven from the same clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i[1:0]`  in  2  per-requester request; held high until granted.
- `we_i[1:0]`  in  2  per-requester write (1) / read (0).
- `addr_i[n]`  in  RWIDTH-2 each  per-requester word address, n = 0,1.
- `wdata_i[n]`  in  32 each  per-requester write data, little-endian (byte k = bits 8k+7:8k).
- `be_i[n]`  in  4 each  per-requester byte enables (writes only).
- `gnt_o[1:0]`  out  2  one-cycle grant pulse; request fields sampled on this cycle.
- `rvalid_o[1:0]`  out  2  one-cycle completion pulse to the granted requester.
- `rdata_o`  out  32  read data, valid with `rvalid_o`; 0 for writes.
- `mem_en_o`  out  1  RAM port enable.
- `mem_we_o`  out  1  RAM port write enable.
- `mem_addr_o`  out  RWIDTH  RAM byte address.
- `mem_wdata_o`  out  8  RAM write byte.
- `mem_rdata_i`  in  8  RAM read byte; synchronous, valid the cycle after `mem_en_o`.

## Operation
- States: IDLE, BYTE, WAIT, RESP.
- IDLE/RESP: if any `req_i`, arbitrate, pulse `gnt_o[w]`, latch we/addr/wdata/be and owner `w`, clear byte counter `cnt`, go BYTE; else go IDLE.
- Round-robin: priority pointer resets to requester 0; if both request, pointer wins; after each grant, pointer = the non-granted requester.
- BYTE (cnt 0..3): `mem_en_o`=1, `mem_addr_o`={addr,cnt}, `mem_wdata_o`=wdata byte cnt, `mem_we_o`=we & be[cnt]. cnt increments; at cnt=3 go WAIT. Always four cycles, including for writes with disabled bytes (byte read, not written).
- Read capture: `mem_rdata_i` in cycle after byte k is stored to rdata byte k (k=0..2 during BYTE, k=3 during WAIT).
- WAIT: capture byte 3, go RESP.
- RESP: `rvalid_o[owner]`=1, `rdata_o`=assembled word (reads) or 0 (writes); new grant allowed in the same cycle.
- All-zero `be` write: completes normally, no RAM byte modified.

## Timing
- Reset values: `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `mem_en_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0; state IDLE; pointer=0.
- Grant at T0; RAM accesses T1..T4; rvalid at T6 (latency 6 from grant). Back-to-back: next grant at T6, next rvalid at T12.
- `gnt_o` and `rvalid_o` at most one bit set; never both high for the same requester except RESP-cycle regrant of that requester (new transaction).
- Requester dropping `req_i` before grant: legal, no transaction.
- Reset mid-transaction: immediate return to reset values; bytes already written stay written; no rvalid issued.
- `mem_*` outputs combinational from state/registers, glitch-free w.r.t. clk_i only.

## Structure
- `dualmem_ctrl_pkg`: state enum, `BYTES_PER_WORD`=4, byte-index width constant.
- Sub-module `dualmem_rr_arb2`: two-input round-robin arbiter (req, advance strobe, one-hot grant, pointer register).

## Test plan
- Req0 write addr 0x10, wdata 0xA1B2C3D4, be 4'hF; then req0 read 0x10 -> mem writes bytes D4,C3,B2,A1 to 0x40..0x43; read rvalid at T6 with rdata 0xA1B2C3D4.
- Write be 4'b0101, wdata 0x11223344 over word 0xFFFFFFFF, then read -> 0xFF22FF44.
- Both req held continuously -> grants alternate 0,1,0,1; each gnt 6 cycles apart; rvalid to correct owner.
- Read at max word address (2^(RWIDTH-2)-1) -> mem_addr_o spans 0x1FFC..0x1FFF for RWIDTH=13, no wrap into 0.
- Assert rst_ni low at T2 of a write -> all outputs 0 immediately, state IDLE, no rvalid; next request serviced normally with pointer 0.
- Single req1 only, req0 idle -> granted at first cycle; pointer then favours req0.
